// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous toggling signal in clk cycles,
// classifies the divide ratio and flags lock, 50% duty and a lost signal.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [2:0]       ratio_code,
  output logic             duty_50,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic [7:0]       meas_count
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hi_lat;
  logic                   has_prev;
  logic                   arm;
  logic                   take_meas;
  logic                   expire;
  logic [2:0]             ratio_next;
  logic                   duty_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise)   state_next = MEASURE;
        MEASURE: if (expire) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A rise landing on the timeout cycle is a real edge, so it takes priority.
  always_comb begin
    arm       = enable && (state == IDLE) && rise;
    take_meas = enable && (state == MEASURE) && rise;
    expire    = enable && (state == MEASURE) && !rise && (cnt == TIMEOUT_CNT);

    ratio_next = 3'd0;
    if      (cnt == CNT_W'(2))  ratio_next = 3'd1;
    else if (cnt == CNT_W'(4))  ratio_next = 3'd2;
    else if (cnt == CNT_W'(8))  ratio_next = 3'd3;
    else if (cnt == CNT_W'(16)) ratio_next = 3'd4;

    duty_next = ({hi_lat, 1'b0} == {1'b0, cnt});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      hi_lat     <= '0;
      has_prev   <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      ratio_code <= 3'd0;
      duty_50    <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      meas_count <= 8'd0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        cnt      <= '0;
        hi_lat   <= '0;
        has_prev <= 1'b0;
        locked   <= 1'b0;
      end else if (arm) begin
        cnt    <= CNT_W'(1);
        hi_lat <= '0;
      end else if (take_meas) begin
        period     <= cnt;
        high_time  <= hi_lat;
        ratio_code <= ratio_next;
        duty_50    <= duty_next;
        meas_valid <= 1'b1;
        meas_count <= meas_count + 8'd1;
        locked     <= has_prev && (cnt == period);
        has_prev   <= 1'b1;
        cnt        <= CNT_W'(1);
        hi_lat     <= '0;
      end else if (expire) begin
        timeout  <= 1'b1;
        locked   <= 1'b0;
        has_prev <= 1'b0;
        cnt      <= '0;
        hi_lat   <= '0;
      end else if (state == MEASURE) begin
        cnt <= cnt + 1'b1;
        if (fall) hi_lat <= cnt;
      end else begin
        cnt    <= '0;
        hi_lat <= '0;
      end
    end
  end

endmodule
